// File: rtl/ro_config_controller_pkg.sv
// ro_config_controller_pkg: shared select width, oscillator count and FSM encodings
package ro_config_controller_pkg;
  localparam int SEL_W = 2;
  localparam int N_RO  = 2;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRAIN  = 3'd1;
  localparam logic [2:0] S_APPLY  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/ro_config_controller_cycle_timer.sv
// ro_config_controller_cycle_timer: loadable down-counter flagging the last cycle of a timed wait
module ro_config_controller_cycle_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] load,
  output logic         expired
);
  logic [W-1:0] cnt;
  // load on start, then count down and park at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (start) cnt <= load;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign expired = cnt == W'(1);
endmodule

// File: rtl/ro_config_controller.sv
// ro_config_controller: glitch-safe select update for the two COSO ring oscillators
module ro_config_controller
  import ro_config_controller_pkg::*;
#(
  parameter int N_STAGES      = 4,
  parameter int DRAIN_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [N_RO*SEL_W*N_STAGES-1:0]    cfg_data,
  output logic [SEL_W*N_STAGES-1:0]         sel_ro0,
  output logic [SEL_W*N_STAGES-1:0]         sel_ro1,
  output logic                              ro_enable,
  output logic                              busy,
  output logic                              cfg_done
);
  localparam int SW = SEL_W * N_STAGES;
  localparam int CW = $clog2(max_int(DRAIN_CYCLES, SETTLE_CYCLES) + 1);
  logic [2:0]      state, nxt;
  logic [2*SW-1:0] shadow;
  logic            configured, accept, start, expired;
  logic [CW-1:0]   load;
  assign cfg_ready = state == S_IDLE;
  assign accept    = cfg_valid & cfg_ready;
  assign start     = accept | (state == S_APPLY);
  assign load      = state == S_APPLY ? CW'(SETTLE_CYCLES) : CW'(DRAIN_CYCLES);
  ro_config_controller_cycle_timer #(.W(CW)) u_timer (
    .clk(clk), .rst_n(rst_n), .start(start), .load(load), .expired(expired)
  );
  // sequence: disable, drain, swap selects, settle, re-enable
  always_comb
    nxt = state == S_IDLE   ? (accept  ? S_DRAIN : S_IDLE)   :
          state == S_DRAIN  ? (expired ? S_APPLY : S_DRAIN)  :
          state == S_APPLY  ? S_SETTLE                       :
          state == S_SETTLE ? (expired ? S_DONE  : S_SETTLE) : S_IDLE;
  // state, shadow and select registers; outputs registered from next state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_IDLE;
      shadow     <= '0;
      sel_ro0    <= '0;
      sel_ro1    <= '0;
      configured <= 1'b0;
      ro_enable  <= 1'b0;
      busy       <= 1'b0;
      cfg_done   <= 1'b0;
    end else begin
      state     <= nxt;
      shadow    <= accept ? cfg_data : shadow;
      sel_ro0   <= state == S_APPLY ? shadow[SW-1:0] : sel_ro0;
      sel_ro1   <= state == S_APPLY ? shadow[2*SW-1:SW] : sel_ro1;
      configured <= configured | (state == S_APPLY);
      ro_enable <= configured & en & (nxt == S_IDLE || nxt == S_DONE);
      busy      <= nxt != S_IDLE;
      cfg_done  <= nxt == S_DONE;
    end
endmodule

// File: tb/tb_ro_config_controller.sv
// tb_ro_config_controller: scoreboard bench for the oscillator configuration sequencer
module tb_ro_config_controller;
  typedef struct packed { logic [7:0] s0; logic [7:0] s1; logic ro; } exp_t;
  logic clk = 1'b0;
  logic rst_n, en, cfg_valid, cfg_ready, ro_enable, busy, cfg_done;
  logic [15:0] cfg_data;
  logic [7:0] sel_ro0, sel_ro1;
  logic b_valid, b_ready, b_ro, b_busy, b_done;
  logic [15:0] b_data;
  logic [7:0] b_sel0, b_sel1;
  exp_t sb[$];
  exp_t m_e;
  int n_chk = 0, n_fail = 0, cyc = 0, acc_cyc = 0, c, c2, t;
  logic [7:0] p0 = '0, p1 = '0;
  logic p_ro = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ro_config_controller dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .sel_ro0(sel_ro0), .sel_ro1(sel_ro1), .ro_enable(ro_enable),
    .busy(busy), .cfg_done(cfg_done)
  );
  ro_config_controller #(.N_STAGES(4), .DRAIN_CYCLES(1), .SETTLE_CYCLES(1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(b_valid), .cfg_ready(b_ready),
    .cfg_data(b_data), .sel_ro0(b_sel0), .sel_ro1(b_sel1), .ro_enable(b_ro),
    .busy(b_busy), .cfg_done(b_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: score every cfg_done pulse and watch for select changes while running
  always @(negedge clk) begin
    if (cfg_valid && cfg_ready) acc_cyc = cyc;
    if (cfg_done) begin
      if (sb.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
      else begin
        m_e = sb.pop_front();
        chk("done_sel0", {24'd0, sel_ro0}, {24'd0, m_e.s0});
        chk("done_sel1", {24'd0, sel_ro1}, {24'd0, m_e.s1});
        chk("done_ro_enable", {31'd0, ro_enable}, {31'd0, m_e.ro});
        chk("done_latency", cyc - acc_cyc, 32'd22);
      end
    end
    if (rst_n && (sel_ro0 != p0 || sel_ro1 != p1))
      chk("sel_change_while_running", {31'd0, ro_enable | p_ro}, 32'd0);
    p0 = sel_ro0;
    p1 = sel_ro1;
    p_ro = ro_enable;
  end

  task automatic wait_ready(output int cc);
    int k = 0;
    @(negedge clk);
    while (!cfg_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!cfg_ready) chk("ready_timeout", 32'd1, 32'd0);
    cc = cyc;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while ((busy || !cfg_ready) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic send(input logic [15:0] d, input logic ro, output int cc);
    @(posedge clk);
    #1 cfg_valid = 1'b1;
    cfg_data = d;
    sb.push_back('{s0: d[7:0], s1: d[15:8], ro: ro});
    wait_ready(cc);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; cfg_valid = 1'b0; cfg_data = '0; b_valid = 1'b0; b_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_sel0", {24'd0, sel_ro0}, 32'd0);
    chk("rst_sel1", {24'd0, sel_ro1}, 32'd0);
    chk("rst_ro_enable", {31'd0, ro_enable}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    chk("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("ro_enable_unconfigured", {31'd0, ro_enable}, 32'd0);
    // first configuration
    send(16'hE41B, 1'b1, c);
    wait_idle();
    chk("ready_return_cycle", cyc - c, 32'd23);
    chk("ro_enable_after_first", {31'd0, ro_enable}, 32'd1);
    // held cfg_valid: second word accepted only after the first completes
    @(posedge clk);
    #1 cfg_valid = 1'b1;
    cfg_data = 16'h1234;
    sb.push_back('{s0: 8'h34, s1: 8'h12, ro: 1'b1});
    wait_ready(c);
    @(posedge clk);
    #1 cfg_data = 16'h5555;
    sb.push_back('{s0: 8'h55, s1: 8'h55, ro: 1'b1});
    @(negedge clk);
    chk("ro_enable_fall", {31'd0, ro_enable}, 32'd0);
    chk("busy_in_seq", {31'd0, busy}, 32'd1);
    chk("ready_in_seq", {31'd0, cfg_ready}, 32'd0);
    repeat (4) @(negedge clk);
    chk("sel0_before_apply", {24'd0, sel_ro0}, 32'h1B);
    @(negedge clk);
    chk("sel0_after_apply", {24'd0, sel_ro0}, 32'h34);
    chk("sel1_after_apply", {24'd0, sel_ro1}, 32'h12);
    wait_ready(c2);
    chk("held_accept_cycle", c2 - c, 32'd23);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    wait_idle();
    // identical word still runs the full sequence
    send(16'h5555, 1'b1, c);
    wait_idle();
    // en dropped mid-sequence
    send(16'h0F0F, 1'b0, c);
    repeat (8) @(negedge clk);
    #1 en = 1'b0;
    wait_idle();
    chk("ro_enable_en_low", {31'd0, ro_enable}, 32'd0);
    @(posedge clk);
    #1 en = 1'b1;
    @(negedge clk);
    chk("en_rise_lag", {31'd0, ro_enable}, 32'd0);
    @(negedge clk);
    chk("en_rise_follow", {31'd0, ro_enable}, 32'd1);
    @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    chk("en_fall_lag", {31'd0, ro_enable}, 32'd1);
    @(negedge clk);
    chk("en_fall_follow", {31'd0, ro_enable}, 32'd0);
    chk("en_toggle_sel0", {24'd0, sel_ro0}, 32'h0F);
    chk("en_toggle_sel1", {24'd0, sel_ro1}, 32'h0F);
    @(posedge clk);
    #1 en = 1'b1;
    repeat (2) @(negedge clk);
    // reset mid-sequence discards the pending configuration
    send(16'hAAAA, 1'b1, c);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sel0", {24'd0, sel_ro0}, 32'd0);
    chk("midrst_sel1", {24'd0, sel_ro1}, 32'd0);
    chk("midrst_ro_enable", {31'd0, ro_enable}, 32'd0);
    chk("midrst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("postrst_ro_enable", {31'd0, ro_enable}, 32'd0);
    // minimum drain/settle instance
    @(posedge clk);
    #1 b_valid = 1'b1;
    b_data = 16'h9C63;
    t = 0;
    @(negedge clk);
    while (!b_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    c = cyc;
    @(posedge clk);
    #1 b_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!b_done && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("fast_latency", cyc - c, 32'd4);
    chk("fast_sel0", {24'd0, b_sel0}, 32'h63);
    chk("fast_sel1", {24'd0, b_sel1}, 32'h9C);
    chk("fast_ro_enable", {31'd0, b_ro}, 32'd1);
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
